// File: rtl/mem_stage_if.sv
// Byte-serial memory port between the MEM stage and the arbitrated memory.
//   master: driven by mem_stage (request side)
//   slave : driven by the memory / arbiter (grant and read-data side)
// Signals:
//   mem_req   byte-transfer request
//   mem_we    1 = write, 0 = read
//   mem_addr  byte address
//   mem_wdata write byte
//   mem_gnt   transfer accepted this cycle when mem_req=1
//   mem_rdata read byte, valid the cycle after an accepted read
interface mem_stage_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_gnt;
  logic [7:0]        mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_gnt,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_gnt,
    output mem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage of the 5-stage RV32I pipeline (between EX/MEM and MEM/WB).
// Non-memory results pass straight through to writeback. Loads and stores
// (LB/LH/LW/LBU/LHU/SB/SH/SW) run as byte-serial little-endian transfers on an
// 8-bit arbitrated port; stallreq is raised while a transfer is in progress.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   in_wd/in_wreg     destination register / write-enable from EX/MEM
//   in_wdata          ALU result from EX/MEM
//   in_aluop          operation code (EXE_*_OP encodings)
//   in_mem_addr       effective byte address
//   in_reg2           store data
//   in_next           one-cycle pulse: new instruction latched into EX/MEM
//   wb_wd/wb_wreg/wb_wdata  results to MEM/WB
//   stallreq          stall request to the pipeline controller
//   misalign          alignment fault pulse
//   mem               byte-serial memory port (mem_stage_if.master)
//
// Optional build macro: MEM_ALIGN_CHECK_EN
//   defined   - halfword/word accesses are alignment-checked in IDLE; a faulting
//               op pulses misalign for one cycle and is not performed
//   undefined - any address is accepted and misalign is constant 0
module mem_stage #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        in_wd,
  input  logic              in_wreg,
  input  logic [31:0]       in_wdata,
  input  logic [7:0]        in_aluop,
  input  logic [ADDR_W-1:0] in_mem_addr,
  input  logic [31:0]       in_reg2,
  input  logic              in_next,
  output logic [4:0]        wb_wd,
  output logic              wb_wreg,
  output logic [31:0]       wb_wdata,
  output logic              stallreq,
  output logic              misalign,
  mem_stage_if.master       mem
);

  // EXE_*_OP encodings for the memory operations.
  localparam logic [7:0] OpLb  = 8'b1110_0000;
  localparam logic [7:0] OpLh  = 8'b1110_0001;
  localparam logic [7:0] OpLw  = 8'b1110_0011;
  localparam logic [7:0] OpLbu = 8'b1110_0100;
  localparam logic [7:0] OpLhu = 8'b1110_0101;
  localparam logic [7:0] OpSb  = 8'b1110_1000;
  localparam logic [7:0] OpSh  = 8'b1110_1001;
  localparam logic [7:0] OpSw  = 8'b1110_1011;

  typedef enum logic [1:0] {StIdle, StAccess, StDrain, StDone} state_e;

  state_e            state_q;
  logic [7:0]        op_q;
  logic [4:0]        wd_q;
  logic              wreg_q;
  logic              is_store_q;
  logic [31:0]       reg2_q;
  logic [2:0]        n_q;
  logic [2:0]        issue_cnt_q;
  logic [2:0]        cap_cnt_q;
  logic              rd_pend_q;
  logic [31:0]       data_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;

  logic              in_is_mem;
  logic              in_is_store;
  logic [2:0]        in_nbytes;
  logic              fault;
  logic              start;
  logic              last_accept;
  logic [7:0]        next_wbyte;
  logic [31:0]       load_data;

  // Decode of the incoming operation.
  always_comb begin
    in_is_mem   = 1'b1;
    in_is_store = 1'b0;
    in_nbytes   = 3'd1;
    case (in_aluop)
      OpLb, OpLbu: in_nbytes = 3'd1;
      OpLh, OpLhu: in_nbytes = 3'd2;
      OpLw:        in_nbytes = 3'd4;
      OpSb: begin
        in_is_store = 1'b1;
        in_nbytes   = 3'd1;
      end
      OpSh: begin
        in_is_store = 1'b1;
        in_nbytes   = 3'd2;
      end
      OpSw: begin
        in_is_store = 1'b1;
        in_nbytes   = 3'd4;
      end
      default: in_is_mem = 1'b0;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_comb begin
    fault = ((in_nbytes == 3'd2) && in_mem_addr[0]) ||
            ((in_nbytes == 3'd4) && (in_mem_addr[1:0] != 2'b00));
  end
`else
  assign fault = 1'b0;
`endif

  assign start       = (state_q == StIdle) && in_next && in_is_mem && !fault;
  assign misalign    = (state_q == StIdle) && in_next && in_is_mem && fault;
  assign last_accept = mem.mem_gnt && ((issue_cnt_q + 3'd1) == n_q);

  // Store byte for the following transfer (byte issue_cnt + 1).
  always_comb begin
    case (issue_cnt_q)
      3'd0:    next_wbyte = reg2_q[15:8];
      3'd1:    next_wbyte = reg2_q[23:16];
      default: next_wbyte = reg2_q[31:24];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= 8'd0;
      wd_q        <= 5'd0;
      wreg_q      <= 1'b0;
      is_store_q  <= 1'b0;
      reg2_q      <= 32'd0;
      n_q         <= 3'd0;
      issue_cnt_q <= 3'd0;
      cap_cnt_q   <= 3'd0;
      rd_pend_q   <= 1'b0;
      data_q      <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
    end else begin
      // Read data arrives the cycle after its accept; land it in the next lane.
      rd_pend_q <= 1'b0;
      if (rd_pend_q) begin
        case (cap_cnt_q)
          3'd0:    data_q[7:0]   <= mem.mem_rdata;
          3'd1:    data_q[15:8]  <= mem.mem_rdata;
          3'd2:    data_q[23:16] <= mem.mem_rdata;
          default: data_q[31:24] <= mem.mem_rdata;
        endcase
        cap_cnt_q <= cap_cnt_q + 3'd1;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_q        <= in_aluop;
            wd_q        <= in_wd;
            wreg_q      <= in_wreg;
            is_store_q  <= in_is_store;
            reg2_q      <= in_reg2;
            n_q         <= in_nbytes;
            issue_cnt_q <= 3'd0;
            cap_cnt_q   <= 3'd0;
            data_q      <= 32'd0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= in_is_store;
            mem_addr_q  <= in_mem_addr;
            mem_wdata_q <= in_reg2[7:0];
            state_q     <= StAccess;
          end
        end
        StAccess: begin
          // Without a grant every request output simply holds.
          if (mem.mem_gnt) begin
            issue_cnt_q <= issue_cnt_q + 3'd1;
            rd_pend_q   <= !is_store_q;
            if (last_accept) begin
              mem_req_q   <= 1'b0;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= '0;
              mem_wdata_q <= 8'd0;
              state_q     <= is_store_q ? StDone : StDrain;
            end else begin
              mem_addr_q  <= mem_addr_q + ADDR_W'(1);
              mem_wdata_q <= next_wbyte;
            end
          end
        end
        StDrain: state_q <= StDone;
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Load result extension.
  always_comb begin
    load_data = data_q;
    case (op_q)
      OpLb:    load_data = {{24{data_q[7]}}, data_q[7:0]};
      OpLbu:   load_data = {24'd0, data_q[7:0]};
      OpLh:    load_data = {{16{data_q[15]}}, data_q[15:0]};
      OpLhu:   load_data = {16'd0, data_q[15:0]};
      default: load_data = data_q;
    endcase
  end

  always_comb begin
    wb_wd    = in_wd;
    wb_wreg  = in_wreg;
    wb_wdata = in_wdata;
    unique case (state_q)
      StIdle: begin
        // A memory op is only written back from DONE.
        if (in_is_mem) wb_wreg = 1'b0;
      end
      StAccess, StDrain: wb_wreg = 1'b0;
      StDone: begin
        wb_wd    = wd_q;
        wb_wreg  = wreg_q && !is_store_q;
        wb_wdata = load_data;
      end
      default: wb_wreg = 1'b0;
    endcase
  end

  assign stallreq = start || (state_q == StAccess) || (state_q == StDrain);

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RV32I pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Non-memory results pass straight through to writeback.
- Loads and stores run as byte-serial little-endian transfers on an 8-bit arbitrated memory port.
- While a transfer is in progress, the block raises stallreq to the pipeline controller.

Parameters:
ADDR_W, 32, byte-address width of mem_addr and in_mem_addr

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
in_wd  input  5  destination register from EX/MEM
in_wreg  input  1  write-enable from EX/MEM
in_wdata  input  32  ALU result from EX/MEM
in_aluop  input  8  operation code (`AluOpBus), EXE_*_OP encodings
in_mem_addr  input  ADDR_W  effective address
in_reg2  input  32  store data
in_next  input  1  one-cycle pulse: new instruction latched into EX/MEM
wb_wd  output  5  destination register to MEM/WB
wb_wreg  output  1  write-enable to MEM/WB
wb_wdata  output  32  writeback data to MEM/WB
stallreq  output  1  stall request to ctrl (freezes stages 0-4)
mem_req  output  1  byte-transfer request
mem_we  output  1  1 = write, 0 = read
mem_addr  output  ADDR_W  byte address
mem_wdata  output  8  write byte
mem_gnt  input  1  transfer accepted this cycle when mem_req=1
mem_rdata  input  8  read byte, valid the cycle after an accepted read
misalign  output  1  alignment fault pulse (tied 0 without the optional feature)

Behaviour:
- Memory ops: LB, LH, LW, LBU, LHU, SB, SH, SW.
  - Byte count N = 1, 2 or 4.
  - Byte i goes to address in_mem_addr + i, little-endian.
- States: IDLE, ACCESS, DRAIN, DONE.
- Reset: state IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, stallreq=0, misalign=0, all internal counters 0.
  - Outputs are combinational from state, so reset forces wb_wreg=0 via IDLE with NOP input.
  - rst mid-transfer abandons the transfer immediately. No further mem_req is issued, and no partial writeback occurs.
- IDLE:
  - Non-memory op: wb_* = in_*, combinational.
  - Memory op with in_next=1:
    - latch op, address, reg2, wd and wreg into internal registers;
    - stallreq=1 combinationally this cycle;
    - wb_wreg=0;
    - next state ACCESS.
  - Memory op with in_next=0 (held instruction already serviced): wb_wreg=0, no access, stallreq=0.
- ACCESS:
  - mem_req=1, mem_addr = base + issue_cnt, mem_we = (op is a store).
  - mem_wdata = reg2 byte[issue_cnt].
  - issue_cnt increments on each mem_gnt.
  - Read data captured into byte[cap_cnt] the cycle after each accepted read.
  - After the final accept:
    - stores go to DONE;
    - loads go to DRAIN, which captures the last byte.
  - stallreq=1 throughout ACCESS and DRAIN.
  - mem_gnt=0 holds all request outputs stable.
- DONE:
  - stallreq=0 and mem_req=0.
  - wb_wd and wb_wreg come from the latched values.
  - wb_wdata for loads:
    - LB / LH: sign-extended;
    - LBU / LHU: zero-extended;
    - LW: the 4 assembled bytes.
  - wb_wreg=0 for stores.
  - Next state IDLE unconditionally.
- Latency with mem_gnt always 1, from the in_next cycle T:
  - LW: DONE at T+6;
  - LB: DONE at T+3;
  - SW: DONE at T+5;
  - SB: DONE at T+2.
- Address arithmetic wraps modulo 2^ADDR_W.
- Counters are 3-bit; the transfer terminates when issue_cnt reaches N.
- in_next during ACCESS/DRAIN/DONE is ignored; the pipeline is frozen then, so it cannot legally occur.

Optional Feature:
MEM_ALIGN_CHECK_EN
- Defined: alignment is checked in IDLE on an in_next memory op.
  - Faults: LH/LHU/SH with addr[0]≠0, or LW/SW with addr[1:0]≠0.
  - On a fault: misalign=1 for that single cycle, no transfer, stallreq=0, wb_wreg=0, state stays IDLE.
- Undefined: any address is accepted (byte-serial access handles misalignment) and misalign is constant 0.

Test Plan:
- Pass-through:
  - Stimulus: ADD op, in_wd=5, in_wreg=1, in_wdata=0x1234, in_next=1.
  - Response: wb_wd=5, wb_wreg=1, wb_wdata=0x1234 the same cycle; stallreq=0, mem_req=0.
- LW:
  - Stimulus: addr 0x100, memory bytes 0x78,0x56,0x34,0xF2, gnt=1.
  - Response: mem_addr 0x100..0x103 issued on consecutive cycles; stallreq high T..T+5; DONE at T+6 with wb_wdata=0xF2345678, wb_wreg=1.
- LB/LBU:
  - Stimulus: byte 0x80 at 0x20.
  - Response: LB gives wb_wdata=0xFFFFFF80; LBU gives 0x00000080.
- SH with gnt stalls:
  - Stimulus: SH addr 0x41, reg2=0xAABBCCDD, gnt low 3 cycles before each accept.
  - Response: writes 0xDD@0x41 then 0xCC@0x42; request outputs stable while gnt=0; wb_wreg=0 at DONE.
- Reset mid-LW:
  - Stimulus: rst asserted after the 2nd accept.
  - Response: next cycle state IDLE, mem_req=0, stallreq=0, wb_wreg=0.
- MEM_ALIGN_CHECK_EN:
  - Stimulus: LW at 0x102.
  - Response: misalign=1 for one cycle, mem_req never asserted, wb_wreg=0.
